// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shared work RAM arbiter: downloader > eraser > CPU, with power-on erase.
// Optional macro RAM_ARB_DRAM_PATTERN_EN: eraser writes the 00/FF DRAM-style pattern instead of ERASE_VALUE.
module ram_arbiter #(
  parameter int                ADDR_W         = 13,
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] ERASE_VALUE    = '0,
  parameter int                ERASE_ON_RESET = 1
) (
  input  logic              clk14,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic              erase_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              erase_busy,
  output logic              erase_done
);

  typedef enum logic {ST_RUN, ST_ERASE} state_t;

  localparam state_t            RESET_STATE = (ERASE_ON_RESET != 0) ? ST_ERASE : ST_RUN;
  localparam logic [ADDR_W-1:0] CNT_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST    = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_erase_cnt;
  logic [ADDR_W-1:0]   w_erase_cnt_nxt;
  logic                r_erase_done;
  logic                w_erase_done_nxt;
  logic [DATA_W-1:0]   w_erase_data;
  logic                w_cpu_wait;
  logic                w_unused;

  // Reads need no strobe, so cpu_rd is intentionally ignored.
  assign w_unused = ^{cpu_rd, ERASE_VALUE};

`ifdef RAM_ARB_DRAM_PATTERN_EN
  assign w_erase_data = {DATA_W{r_erase_cnt[0]}};
`else
  assign w_erase_data = ERASE_VALUE;
`endif

  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      r_state      <= RESET_STATE;
      r_erase_cnt  <= '0;
      r_erase_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_erase_cnt  <= w_erase_cnt_nxt;
      r_erase_done <= w_erase_done_nxt;
    end
  end

  // The eraser only advances on cycles it actually owns the RAM.
  always_comb begin
    w_state_nxt      = r_state;
    w_erase_cnt_nxt  = r_erase_cnt;
    w_erase_done_nxt = 1'b0;
    case (r_state)
      ST_ERASE: begin
        if (!dl_wr) begin
          w_erase_cnt_nxt = r_erase_cnt + CNT_ONE;
          if (r_erase_cnt == CNT_LAST) begin
            w_state_nxt      = ST_RUN;
            w_erase_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (erase_req) begin
          w_state_nxt     = ST_ERASE;
          w_erase_cnt_nxt = '0;
        end
      end
    endcase
  end

  assign w_cpu_wait = reset | (r_state == ST_ERASE) | dl_active | dl_wr;

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (!reset) begin
      if (dl_wr) begin
        ram_addr = dl_addr;
        ram_din  = dl_data;
        ram_we   = 1'b1;
      end else if (r_state == ST_ERASE) begin
        ram_addr = r_erase_cnt;
        ram_din  = w_erase_data;
        ram_we   = 1'b1;
      end else begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_wr & ~w_cpu_wait;
      end
    end
  end

  assign cpu_wait   = w_cpu_wait;
  assign erase_busy = (r_state == ST_ERASE);
  assign erase_done = r_erase_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter (ADDR_W=4).
module tb_ram_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk14 = 1'b0;
  logic          reset = 1'b1;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic          erase_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          cpu_wr = 1'b0;
  logic          cpu_rd = 1'b0;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          erase_busy;
  logic          erase_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] ram_mem [DEPTH];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ERASE_VALUE(8'h00), .ERASE_ON_RESET(1)) dut (
    .clk14(clk14), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .erase_req(erase_req),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_wait(cpu_wait), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .erase_busy(erase_busy), .erase_done(erase_done)
  );

  always #5 clk14 = ~clk14;

  always @(posedge clk14) if (ram_we) ram_mem[ram_addr] <= ram_din;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] erase_byte(input int a);
`ifdef RAM_ARB_DRAM_PATTERN_EN
    return (a % 2 == 1) ? 8'hFF : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk14); #1;
    n_checks += 6;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", ram_we); end
    if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", ram_addr); end
    if (ram_din !== '0) begin n_fail++; $display("FAIL reset_din got %h want 0", ram_din); end
    if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL reset_wait got %b want 1", cpu_wait); end
    if (erase_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", erase_busy); end
    if (erase_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", erase_done); end
  endtask

  task automatic test_erase_full();
    @(negedge clk14); reset = 1'b0; #1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) begin @(negedge clk14); #1; end
      n_checks += 5;
      if (ram_we !== 1'b1) begin n_fail++; $display("FAIL erase_we[%0d] got %b want 1", k, ram_we); end
      if (ram_addr !== AW'(k)) begin n_fail++; $display("FAIL erase_addr[%0d] got %0d want %0d", k, ram_addr, k); end
      if (ram_din !== erase_byte(k)) begin n_fail++; $display("FAIL erase_din[%0d] got %h want %h", k, ram_din, erase_byte(k)); end
      if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL erase_wait[%0d] got %b want 1", k, cpu_wait); end
      if (erase_done !== 1'b0) begin n_fail++; $display("FAIL erase_early_done[%0d] got %b want 0", k, erase_done); end
    end
    @(negedge clk14); #1;
    n_checks += 3;
    if (erase_done !== 1'b1) begin n_fail++; $display("FAIL erase_done_pulse got %b want 1", erase_done); end
    if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL erase_wait_drop got %b want 0", cpu_wait); end
    if (erase_busy !== 1'b0) begin n_fail++; $display("FAIL erase_busy_drop got %b want 0", erase_busy); end
    @(negedge clk14); #1;
    n_checks++;
    if (erase_done !== 1'b0) begin n_fail++; $display("FAIL erase_done_width got %b want 0", erase_done); end
  endtask

  task automatic test_cpu_run();
    logic          e_we, e_wait;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk14);
      dl_active = ($urandom_range(0, 2) == 0);
      dl_wr     = ($urandom_range(0, 3) == 0);
      dl_addr   = AW'($urandom);
      dl_data   = DW'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_din   = DW'($urandom);
      cpu_wr    = $urandom_range(0, 1) == 1;
      cpu_rd    = !cpu_wr;
      #1;
      e_wait = dl_active || dl_wr;
      e_we   = dl_wr || (cpu_wr && !e_wait);
      e_addr = dl_wr ? dl_addr : cpu_addr;
      e_din  = dl_wr ? dl_data : cpu_din;
      n_checks += 3;
      if (cpu_wait !== e_wait) begin n_fail++; $display("FAIL run_wait[%0d] got %b want %b", i, cpu_wait, e_wait); end
      if (ram_we !== e_we) begin n_fail++; $display("FAIL run_we[%0d] got %b want %b", i, ram_we, e_we); end
      if (e_we) begin
        n_checks += 2;
        if (ram_addr !== e_addr) begin n_fail++; $display("FAIL run_addr[%0d] got %h want %h", i, ram_addr, e_addr); end
        if (ram_din !== e_din) begin n_fail++; $display("FAIL run_din[%0d] got %h want %h", i, ram_din, e_din); end
      end
    end
    @(negedge clk14);
    dl_active = 1'b0; dl_wr = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic test_dl_active_release();
    @(negedge clk14);
    dl_active = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h3; cpu_din = 8'h42;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk14);
      #1;
      n_checks += 2;
      if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL hold_wait[%0d] got %b want 1", i, cpu_wait); end
      if (ram_we !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d] got %b want 0", i, ram_we); end
    end
    @(negedge clk14); dl_active = 1'b0; #1;
    n_checks += 4;
    if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL release_wait got %b want 0", cpu_wait); end
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL release_we got %b want 1", ram_we); end
    if (ram_addr !== 4'h3) begin n_fail++; $display("FAIL release_addr got %h want 3", ram_addr); end
    if (ram_din !== 8'h42) begin n_fail++; $display("FAIL release_din got %h want 42", ram_din); end
    @(negedge clk14); cpu_wr = 1'b0;
  endtask

  task automatic test_erase_with_dl();
    int  p, exp_ptr, cyc;
    bit  done_seen;
    p = $urandom_range(1, 13);
    exp_ptr = 0; cyc = 0; done_seen = 0;
    @(negedge clk14); erase_req = 1'b1; #1;
    n_checks++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL req_cycle_we got %b want 0", ram_we); end
    while (!done_seen && cyc < 40) begin
      @(negedge clk14);
      erase_req = 1'b0;
      dl_wr = (cyc == p) || (cyc == p + 1);
      dl_addr = 4'h5; dl_data = 8'hA9;
      #1;
      if (exp_ptr == DEPTH) begin
        done_seen = 1;
        n_checks += 2;
        if (erase_done !== 1'b1) begin n_fail++; $display("FAIL dl_erase_done got %b want 1", erase_done); end
        if (cyc != 18) begin n_fail++; $display("FAIL dl_erase_len got %0d want 18", cyc); end
      end else begin
        n_checks += 4;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL dl_erase_we[%0d] got %b want 1", cyc, ram_we); end
        if (erase_done !== 1'b0) begin n_fail++; $display("FAIL dl_erase_early[%0d] got %b want 0", cyc, erase_done); end
        if (dl_wr) begin
          if (ram_addr !== 4'h5) begin n_fail++; $display("FAIL dl_grant_addr[%0d] got %h want 5", cyc, ram_addr); end
          if (ram_din !== 8'hA9) begin n_fail++; $display("FAIL dl_grant_din[%0d] got %h want a9", cyc, ram_din); end
        end else begin
          if (ram_addr !== AW'(exp_ptr)) begin n_fail++; $display("FAIL dl_erase_addr[%0d] got %0d want %0d", cyc, ram_addr, exp_ptr); end
          if (ram_din !== erase_byte(exp_ptr)) begin n_fail++; $display("FAIL dl_erase_din[%0d] got %h want %h", cyc, ram_din, erase_byte(exp_ptr)); end
          exp_ptr++;
        end
      end
      cyc++;
    end
    dl_wr = 1'b0;
    if (!done_seen) begin n_checks++; n_fail++; $display("FAIL dl_erase_timeout got no done want done"); end
    @(negedge clk14); #1;
    n_checks++;
    if (erase_done !== 1'b0) begin n_fail++; $display("FAIL dl_erase_done_width got %b want 0", erase_done); end
  endtask

  task automatic test_erase_req_collision();
    int r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom); d = DW'($urandom);
    r = $urandom_range(2, 12);
    @(negedge clk14); erase_req = 1'b1; dl_wr = 1'b1; dl_addr = a; dl_data = d; #1;
    n_checks += 3;
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL coll_we got %b want 1", ram_we); end
    if (ram_addr !== a) begin n_fail++; $display("FAIL coll_addr got %h want %h", ram_addr, a); end
    if (ram_din !== d) begin n_fail++; $display("FAIL coll_din got %h want %h", ram_din, d); end
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk14);
      dl_wr = 1'b0;
      erase_req = (k == r);
      #1;
      n_checks += 3;
      if (erase_busy !== 1'b1) begin n_fail++; $display("FAIL coll_busy[%0d] got %b want 1", k, erase_busy); end
      if (ram_addr !== AW'(k)) begin n_fail++; $display("FAIL coll_addr_seq[%0d] got %0d want %0d", k, ram_addr, k); end
      if (ram_din !== erase_byte(k)) begin n_fail++; $display("FAIL coll_din_seq[%0d] got %h want %h", k, ram_din, erase_byte(k)); end
    end
    @(negedge clk14); erase_req = 1'b0; #1;
    n_checks++;
    if (erase_done !== 1'b1) begin n_fail++; $display("FAIL coll_done got %b want 1", erase_done); end
  endtask

  task automatic test_reset_mid_erase();
    @(negedge clk14); erase_req = 1'b1; #1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk14); erase_req = 1'b0; #1;
      n_checks++;
      if (ram_addr !== AW'(k)) begin n_fail++; $display("FAIL pre_reset_addr[%0d] got %0d want %0d", k, ram_addr, k); end
    end
    @(negedge clk14); reset = 1'b1; #1;
    n_checks += 2;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_we got %b want 0", ram_we); end
    if (cpu_wait !== 1'b1) begin n_fail++; $display("FAIL mid_reset_wait got %b want 1", cpu_wait); end
    test_erase_full();
  endtask

  task automatic test_ram_contents();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (ram_mem[i] !== erase_byte(i)) begin n_fail++; $display("FAIL ram_content[%0d] got %h want %h", i, ram_mem[i], erase_byte(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_erase_full();
    test_cpu_run();
    test_dl_active_release();
    test_erase_with_dl();
    test_erase_req_collision();
    test_reset_mid_erase();
    test_ram_contents();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
